// File: rtl/grom_io_ports.sv
// grom_io_ports: IO peripheral for the grom CPU bus.
//
// Decodes IO cycles (ioreq=1) in a window starting at BASE_ADDR:
//   +0            CONSOLE  write pushes into a first-word-fall-through FIFO;
//                          read peeks the head (0 when empty), never pops
//   +1            STATUS   read {0.., overflow, full, empty}; any write clears overflow
//   +2..+NUM_OUT+1 OUT[k]  general output latches with readback
//   other         reads 0, writes ignored
// The FIFO is drained by a valid/ready consumer (bench monitor, future UART).
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   addr/data_in/we/ioreq  CPU bus request
//   data_out          combinational read data (0 unless an IO read)
//   port_out          latch k at [k*DATA_WIDTH +: DATA_WIDTH]
//   con_data/con_valid/con_ready  FIFO head handshake
//   con_level         current FIFO occupancy

// One output latch register.
module grom_io_latch #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end
endmodule

module grom_io_ports #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 8,
  parameter int                    NUM_OUT    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          we,
  input  logic                          ioreq,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [NUM_OUT*DATA_WIDTH-1:0] port_out,
  output logic [DATA_WIDTH-1:0]         con_data,
  output logic                          con_valid,
  input  logic                          con_ready,
  output logic [$clog2(FIFO_DEPTH):0]   con_level
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_CON  = '0;
  localparam logic [ADDR_WIDTH-1:0] OFF_STAT = ADDR_WIDTH'(1);

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] off;
    logic [DATA_WIDTH-1:0] wdata;
  } bus_req_t;

  bus_req_t req;

  // Writes are qualified by reset so bus traffic during reset is dropped.
  assign req.rd    = ioreq & ~we;
  assign req.wr    = ioreq & we & reset;
  assign req.off   = addr - BASE_ADDR;
  assign req.wdata = data_in;

  logic sel_con, sel_stat;
  assign sel_con  = (req.off == OFF_CON);
  assign sel_stat = (req.off == OFF_STAT);

  // ---------------- output latches ----------------
  logic [NUM_OUT-1:0]                 out_sel;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0] port_q;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_sel[k] = (req.off == ADDR_WIDTH'(k + 2));
    grom_io_latch #(.DATA_WIDTH(DATA_WIDTH)) u_latch (
      .clk   (clk),
      .reset (reset),
      .en    (req.wr & out_sel[k]),
      .d     (req.wdata),
      .q     (port_q[k])
    );
  end

  assign port_out = port_q;

  // ---------------- console FIFO ----------------
  // Pointers carry one extra lap bit: equal pointers mean empty, equal index
  // with differing lap bit means full.
  logic [PW-1:0]         wptr, rptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  empty, full, overflow;
  logic                  push, pop, push_ok, ovf_set;

  assign empty = (wptr == rptr);
  assign full  = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);

  assign pop     = ~empty & con_ready;
  assign push    = req.wr & sel_con;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      if (ovf_set)                   overflow <= 1'b1;
      else if (req.wr & sel_stat)    overflow <= 1'b0;
    end
  end

  // Storage is not reset; occupancy is defined purely by the pointers.
  // When full with a pop, the write slot equals the read slot being vacated.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[IW-1:0]] <= req.wdata;
  end

  assign con_valid = ~empty;
  assign con_data  = mem[rptr[IW-1:0]];
  assign con_level = wptr - rptr;

  // ---------------- read mux ----------------
  always_comb begin
    data_out = '0;
    if (req.rd) begin
      if (sel_con && !empty) data_out = con_data;
      if (sel_stat)          data_out = DATA_WIDTH'({overflow, full, empty});
      for (int k = 0; k < NUM_OUT; k++) begin
        if (out_sel[k]) data_out = port_q[k];
      end
    end
  end

endmodule

// File: tb/tb_grom_io_ports.sv
module tb_grom_io_ports;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int NO = 4;
  localparam int LW = $clog2(D) + 1;
  localparam logic [AW-1:0] BASE = 12'h000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic          we = 1'b0;
  logic          ioreq = 1'b0;
  logic [DW-1:0] data_out;
  logic [NO*DW-1:0] port_out;
  logic [DW-1:0] con_data;
  logic          con_valid;
  logic          con_ready = 1'b0;
  logic [LW-1:0] con_level;

  always #5 clk = ~clk;

  grom_io_ports #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
    .FIFO_DEPTH(D), .NUM_OUT(NO)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .data_in(data_in), .we(we),
    .ioreq(ioreq), .data_out(data_out), .port_out(port_out),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
    .con_level(con_level)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned  q[$];
  bit            ovf;
  logic [DW-1:0] lat [NO];
  logic [AW-1:0] m_off;
  bit            m_pop;

  always @(posedge clk) begin
    m_off = addr - BASE;
    if (!reset) begin
      q.delete();
      ovf = 0;
      for (int k = 0; k < NO; k++) lat[k] = '0;
    end else begin
      m_pop = (q.size() != 0) && con_ready;
      if (m_pop) void'(q.pop_front());
      if (ioreq && we) begin
        if (m_off == 0) begin
          if (q.size() < D) q.push_back(data_in);
          else              ovf = 1;
        end else if (m_off == 1) begin
          ovf = 0;
        end else if (m_off < AW'(NO + 2)) begin
          lat[m_off - 2] = data_in;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a);
    logic [AW-1:0] o;
    o = a - BASE;
    if (o == 0) return (q.size() != 0) ? DW'(q[0]) : '0;
    if (o == 1) return DW'({ovf, q.size() == D, q.size() == 0});
    if (o < AW'(NO + 2)) return lat[o - 2];
    return '0;
  endfunction

  // One compare process: all outputs checked against the model every cycle.
  logic [NO*DW-1:0] exp_port;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NO; k++) exp_port[k*DW +: DW] = lat[k];
      chk("con_valid", con_valid, q.size() != 0);
      chk("con_level", con_level, q.size());
      if (q.size() != 0) chk("con_data", con_data, q[0]);
      chk("port_out", port_out, exp_port);
      if (!ioreq)   chk("data_out_idle", data_out, 0);
      else if (!we) chk("data_out_rd", data_out, exp_rd(addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic io_wr(logic [AW-1:0] a, logic [DW-1:0] d);
    ioreq = 1; we = 1; addr = a; data_in = d;
    step();
    ioreq = 0; we = 0;
  endtask

  task automatic io_rd(logic [AW-1:0] a, string name, logic [DW-1:0] exp);
    ioreq = 1; we = 0; addr = a;
    #1;
    chk(name, data_out, exp);
    step();
    ioreq = 0;
  endtask

  byte unsigned got[$];

  initial begin
    // 1. reset
    reset = 0;
    step(); step();
    reset = 1;
    chk_en = 1;
    chk("rst_port", port_out, 0);
    chk("rst_valid", con_valid, 0);
    chk("rst_level", con_level, 0);
    io_rd(BASE + 1, "rst_status", 8'h01);

    // 2. basic push then drain
    con_ready = 0;
    io_wr(BASE, 8'h41); io_wr(BASE, 8'h42); io_wr(BASE, 8'h43);
    chk("t2_level", con_level, 3);
    chk("t2_head", con_data, 8'h41);
    io_rd(BASE, "t2_peek", 8'h41);
    chk("t2_nopop", con_level, 3);
    con_ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_drain", con_data, 8'h41 + i);
      step();
    end
    chk("t2_empty", con_valid, 0);
    con_ready = 0;

    // 3. overflow
    for (int i = 0; i < 10; i++) io_wr(BASE, DW'(i));
    chk("t3_level", con_level, 8);
    io_rd(BASE + 1, "t3_status", 8'h06);
    con_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", con_data, i);
      step();
    end
    con_ready = 0;
    io_rd(BASE + 1, "t3_sticky", 8'h05);
    io_wr(BASE + 1, 8'h00);
    io_rd(BASE + 1, "t3_clear", 8'h01);

    // 4. full with simultaneous pop and push
    for (int i = 0; i < 8; i++) io_wr(BASE, 8'h10 + DW'(i));
    con_ready = 1;
    io_wr(BASE, 8'hAA);
    chk("t4_level", con_level, 8);
    chk("t4_head", con_data, 8'h11);
    con_ready = 0;
    io_rd(BASE + 1, "t4_status", 8'h02);
    con_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t4_drain", con_data, (i < 7) ? 8'h11 + i : 8'hAA);
      step();
    end
    chk("t4_empty", con_valid, 0);
    con_ready = 0;

    // 5. output latches
    for (int k = 0; k < NO; k++) io_wr(BASE + AW'(2 + k), 8'h11 * (k + 1));
    chk("t5_port", port_out, 32'h44332211);
    for (int k = 0; k < NO; k++) io_rd(BASE + AW'(2 + k), "t5_readback", 8'h11 * (k + 1));
    io_wr(BASE + 6, 8'h55);
    chk("t5_hole_port", port_out, 32'h44332211);
    io_rd(BASE + 6, "t5_hole_rd", 8'h00);

    // 6a. stream with toggling ready; collect what the consumer takes
    for (int i = 0; i < 40; i++) begin
      con_ready = i[0];
      if (!i[0]) begin ioreq = 1; we = 1; addr = BASE; data_in = 8'h60 + DW'(i / 2); end
      else       begin ioreq = 0; we = 0; end
      #1;
      if (con_valid && con_ready) got.push_back(con_data);
      step();
    end
    ioreq = 0; we = 0; con_ready = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (con_valid) got.push_back(con_data);
      step();
    end
    con_ready = 0;
    chk("t6_count", got.size(), 20);
    for (int i = 0; i < got.size() && i < 20; i++) chk("t6_order", got[i], 8'h60 + i);

    // 6b. mid-transfer reset with level 5 and overflow set
    for (int i = 0; i < 9; i++) io_wr(BASE, 8'h80 + DW'(i));
    con_ready = 1; step(); step(); step(); con_ready = 0;
    chk("t6_level5", con_level, 5);
    reset = 0;
    ioreq = 1; we = 1; addr = BASE + 2; data_in = 8'h99;
    step();
    reset = 1; ioreq = 0; we = 0;
    chk("t6_rst_valid", con_valid, 0);
    chk("t6_rst_level", con_level, 0);
    chk("t6_rst_port", port_out, 0);
    io_rd(BASE + 1, "t6_rst_status", 8'h01);

    // 6c. writes without ioreq are ignored
    ioreq = 0; we = 1; addr = BASE; data_in = 8'h77;
    step();
    we = 0;
    chk("t6_noioreq", con_level, 0);

    // random traffic, checked every cycle by the compare process
    for (int n = 0; n < 800; n++) begin
      reset     = ($urandom_range(0, 99) != 0);
      ioreq     = ($urandom_range(0, 3) != 0);
      we        = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        8:       addr = 12'hFFF;
        9:       addr = 12'h100;
        default: addr = BASE + AW'($urandom_range(0, 7));
      endcase
      if ($urandom_range(0, 1) == 1 && addr == BASE) addr = BASE;
      data_in   = DW'($urandom);
      con_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    reset = 1; ioreq = 0; we = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
